seg_cla_adder: RTL and testbench

Parametrised, multi-cycle segmented carry-lookahead adder/subtractor. Each operand pair is latched on a valid/ready handshake. The adder then processes one SEG-bit lookahead segment per clock, chaining the carry through a register, and presents a registered sum, carry and signed-overflow result under an output valid/ready handshake. It generalises the combinational 16-bit CLA adder to arbitrary width and area/latency trade-off, adds subtract mode, and is the adder used by the team's sequential datapath blocks.

---
 rtl/seg_cla_adder.sv | 124 ++++++++++++
 tb/tb_seg_cla_adder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_cla_adder.sv
// Multi-cycle segmented carry-lookahead adder/subtractor: one SEG-bit lookahead
// segment per clock, carry chained through a register, result under valid/ready.
module seg_cla_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned NSEG = WIDTH / SEG;
   localparam int unsigned CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_r, b_r, acc, acc_next;
   logic             cy_r;
   logic [CW-1:0]    seg_cnt;

   logic [SEG-1:0]   seg_a, seg_b, g, p, seg_sum;
   logic [SEG:0]     c;
   logic             prop;
   logic             last;

   assign last      = (seg_cnt == CW'(NSEG - 1));
   assign in_ready  = (state == StIdle);
   assign out_valid = (state == StDone);

   always_comb begin
      seg_a = '0;
      seg_b = '0;
      for (int i = 0; i < NSEG; i++) begin
         if (seg_cnt == CW'(i)) begin
            seg_a = a_r[i*SEG +: SEG];
            seg_b = b_r[i*SEG +: SEG];
         end
      end
      g = seg_a & seg_b;
      p = seg_a ^ seg_b;

      // Each carry is a flat sum of products over g/p and cy_r, not a ripple chain.
      c    = '0;
      c[0] = cy_r;
      prop = 1'b0;
      for (int j = 0; j < SEG; j++) begin
         c[j+1] = g[j];
         prop   = p[j];
         for (int k = j - 1; k >= 0; k--) begin
            c[j+1] = c[j+1] | (prop & g[k]);
            prop   = prop & p[k];
         end
         c[j+1] = c[j+1] | (prop & cy_r);
      end
      seg_sum = p ^ c[SEG-1:0];

      acc_next = acc;
      for (int i = 0; i < NSEG; i++) begin
         if (seg_cnt == CW'(i)) begin
            acc_next[i*SEG +: SEG] = seg_sum;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         StIdle:  if (in_valid) state_next = StRun;
         StRun:   if (last) state_next = StDone;
         StDone:  if (out_ready) state_next = StIdle;
         default: state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         a_r       <= '0;
         b_r       <= '0;
         cy_r      <= 1'b0;
         seg_cnt   <= '0;
         acc       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            StIdle: begin
               if (in_valid) begin
                  a_r     <= a;
                  b_r     <= sub ? ~b : b;
                  cy_r    <= carry_in ^ sub;
                  seg_cnt <= '0;
               end
            end
            StRun: begin
               acc     <= acc_next;
               cy_r    <= c[SEG];
               seg_cnt <= seg_cnt + CW'(1);
               if (last) begin
                  sum       <= acc_next;
                  carry_out <= c[SEG];
                  // c[SEG-1] of the last segment is the carry into bit WIDTH-1.
                  overflow  <= c[SEG] ^ c[SEG-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_cla_adder.sv
// Directed and randomised checks of seg_cla_adder, including a sweep over
// several WIDTH/SEG configurations against a behavioural model.
module tb_seg_cla_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, carry_in, sub;
   logic [15:0] a, b;
   logic        in_ready, out_valid, carry_out, overflow;
   logic [15:0] sum;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_cla_adder #(.WIDTH(16), .SEG(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .carry_in(carry_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry_out(carry_out), .overflow(overflow)
   );

   // Sweep instances share one stimulus bus.
   logic [31:0] sw_a, sw_b;
   logic        sw_cin, sw_sub, sw_valid;
   logic [3:0]  sw_rdy, sw_ov, sw_co, sw_of;
   logic [15:0] s_sum0, s_sum1, s_sum2;
   logic [31:0] s_sum3;

   seg_cla_adder #(.WIDTH(16), .SEG(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[0]), .a(sw_a[15:0]),
      .b(sw_b[15:0]), .carry_in(sw_cin), .sub(sw_sub), .out_valid(sw_ov[0]),
      .out_ready(1'b1), .sum(s_sum0), .carry_out(sw_co[0]), .overflow(sw_of[0])
   );
   seg_cla_adder #(.WIDTH(16), .SEG(16)) u_s16 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[1]), .a(sw_a[15:0]),
      .b(sw_b[15:0]), .carry_in(sw_cin), .sub(sw_sub), .out_valid(sw_ov[1]),
      .out_ready(1'b1), .sum(s_sum1), .carry_out(sw_co[1]), .overflow(sw_of[1])
   );
   seg_cla_adder #(.WIDTH(16), .SEG(8)) u_s8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[2]), .a(sw_a[15:0]),
      .b(sw_b[15:0]), .carry_in(sw_cin), .sub(sw_sub), .out_valid(sw_ov[2]),
      .out_ready(1'b1), .sum(s_sum2), .carry_out(sw_co[2]), .overflow(sw_of[2])
   );
   seg_cla_adder #(.WIDTH(32), .SEG(8)) u_w32 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[3]), .a(sw_a),
      .b(sw_b), .carry_in(sw_cin), .sub(sw_sub), .out_valid(sw_ov[3]),
      .out_ready(1'b1), .sum(s_sum3), .carry_out(sw_co[3]), .overflow(sw_of[3])
   );

   // Returns {overflow, carry_out, sum[31:0]}.
   function automatic logic [33:0] model(input int w, input logic [31:0] x, y,
                                          input logic ci, sb);
      logic [63:0] mask, xx, yy, full, sm;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      xx   = {32'b0, x} & mask;
      yy   = (sb ? ~{32'b0, y} : {32'b0, y}) & mask;
      full = xx + yy + {63'b0, ci ^ sb};
      sm   = full & mask;
      co   = full[w];
      ov   = (xx[w-1] == yy[w-1]) && (sm[w-1] != xx[w-1]);
      return {ov, co, sm[31:0]};
   endfunction

   task automatic do_op(input logic [15:0] opa, opb, input logic ci, sb,
                        input logic [15:0] es, input logic eco, eov, input string name);
      int lat;
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      a = opa; b = opb; carry_in = ci; sub = sb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      n_vec++;
      if (lat !== 4) begin
         n_err++;
         $display("FAIL %s latency: got %0d want 4", name, lat);
      end
      n_vec++;
      if ({sum, carry_out, overflow} !== {es, eco, eov}) begin
         n_err++;
         $display("FAIL %s: got sum=%0d co=%b ov=%b want sum=%0d co=%b ov=%b",
                  name, sum, carry_out, overflow, es, eco, eov);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      carry_in = 1'b0; sub = 1'b0;
      sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_vec++;
      if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0})
      begin
         n_err++;
         $display("FAIL reset: got rdy=%b vld=%b sum=%0d co=%b ov=%b want 1 0 0 0 0",
                  in_ready, out_valid, sum, carry_out, overflow);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      do_op(16'd10, 16'd22, 1'b0, 1'b0, 16'd32, 1'b0, 1'b0, "add");
      do_op(16'd10, 16'd22, 1'b1, 1'b0, 16'd33, 1'b0, 1'b0, "add_cin");
   endtask

   task automatic test_overflow();
      do_op(16'd32768, 16'd65535, 1'b0, 1'b0, 16'd32767, 1'b1, 1'b1, "ovf_neg");
      do_op(16'd32767, 16'd32767, 1'b1, 1'b0, 16'd65535, 1'b0, 1'b1, "ovf_pos");
      do_op(16'd65535, 16'd65535, 1'b0, 1'b0, 16'd65534, 1'b1, 1'b0, "all_ones");
      do_op(16'd0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "zero");
   endtask

   task automatic test_sub();
      do_op(16'd10, 16'd22, 1'b0, 1'b1, 16'd65524, 1'b0, 1'b0, "sub_neg");
      do_op(16'd22, 16'd10, 1'b1, 1'b1, 16'd11, 1'b1, 1'b0, "sub_borrow");
      do_op(16'd32768, 16'd1, 1'b0, 1'b1, 16'd32767, 1'b1, 1'b1, "sub_ovf");
   endtask

   task automatic test_handshake();
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      out_ready = 1'b0;
      a = 16'd1000; b = 16'd234; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'd5; b = 16'd5; in_valid = 1'b1;   // must be ignored during RUN
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({out_valid, in_ready, sum, carry_out, overflow} !==
             {1'b1, 1'b0, 16'd1234, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL hold[%0d]: got vld=%b rdy=%b sum=%0d want vld=1 rdy=0 sum=1234",
                     i, out_valid, in_ready, sum);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 16'd1234}) begin
         n_err++;
         $display("FAIL release: got rdy=%b vld=%b sum=%0d want rdy=1 vld=0 sum=1234",
                  in_ready, out_valid, sum);
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      int lat;
      out_ready = 1'b1;
      a = 16'd10; b = 16'd22; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;   // accept edge t0
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(posedge clk); #1; cnt++;
         if (out_valid) begin
            n_vec++;
            if (sum !== 16'd32) begin
               n_err++;
               $display("FAIL b2b_first: got sum=%0d want 32", sum);
            end
         end
      end
      n_vec++;
      if (cnt !== 5) begin
         n_err++;
         $display("FAIL b2b_ready: in_ready after %0d edges want 5", cnt);
      end
      a = 16'd100; b = 16'd200;
      @(posedge clk); #1;   // accept edge t0+NSEG+2
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      n_vec++;
      if (lat !== 4 || sum !== 16'd300) begin
         n_err++;
         $display("FAIL b2b_second: got lat=%0d sum=%0d want lat=4 sum=300", lat, sum);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      a = 16'd10; b = 16'd22; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;   // seg_cnt = 2
      n_vec++;
      if (sum !== 16'd300 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL run_hold: got sum=%0d rdy=%b want sum=300 rdy=0", sum, in_ready);
      end
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0})
      begin
         n_err++;
         $display("FAIL async_reset: got rdy=%b vld=%b sum=%0d co=%b ov=%b want 1 0 0 0 0",
                  in_ready, out_valid, sum, carry_out, overflow);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL aborted[%0d]: got vld=%b rdy=%b want vld=0 rdy=1",
                     i, out_valid, in_ready);
         end
      end
      do_op(16'd10, 16'd22, 1'b0, 1'b0, 16'd32, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_sweep();
      int          widths[4] = '{16, 16, 16, 32};
      int          nsegs[4]  = '{16, 1, 2, 4};
      logic [3:0]  seen;
      logic [33:0] exp_r, got_r;
      logic [31:0] got_s;
      int          guard;
      for (int v = 0; v < 1000; v++) begin
         guard = 0;
         while (sw_rdy !== 4'hF && guard < 50) begin
            @(posedge clk); #1; guard++;
         end
         sw_a = $urandom; sw_b = $urandom;
         sw_cin = 1'($urandom_range(1)); sw_sub = 1'($urandom_range(1));
         sw_valid = 1'b1;
         @(posedge clk); #1;
         sw_valid = 1'b0;
         seen = '0;
         for (int cyc = 1; cyc <= 40 && seen != 4'hF; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
               if (sw_ov[k] && !seen[k]) begin
                  seen[k] = 1'b1;
                  case (k)
                     0:       got_s = {16'b0, s_sum0};
                     1:       got_s = {16'b0, s_sum1};
                     2:       got_s = {16'b0, s_sum2};
                     default: got_s = s_sum3;
                  endcase
                  got_r = {sw_of[k], sw_co[k], got_s};
                  exp_r = model(widths[k], sw_a, sw_b, sw_cin, sw_sub);
                  n_vec++;
                  if (cyc !== nsegs[k] || got_r !== exp_r) begin
                     n_err++;
                     $display("FAIL sweep cfg%0d v%0d a=%h b=%h ci=%b sub=%b: got lat=%0d r=%h want lat=%0d r=%h",
                              k, v, sw_a, sw_b, sw_cin, sw_sub, cyc, got_r, nsegs[k], exp_r);
                  end
               end
            end
         end
         n_vec++;
         if (seen !== 4'hF) begin
            n_err++;
            $display("FAIL sweep_timeout v%0d: completed=%b want 1111", v, seen);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_overflow();
      test_sub();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
